// File: rtl/spike_rate_encoder_pkg.sv
// Shared types, constants and LFSR step function for the spike rate encoder.
// Both the RTL and the testbench model use the same LFSR step function.
package spike_enc_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } enc_state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One step of a 16-bit right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample handshake and spike-train outputs of the spike rate encoder.
interface spike_rate_encoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WINDOW     = 16
);
    localparam int CNT_W = $clog2(WINDOW + 1);

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  spike_out;
    logic                  window_active;
    logic                  window_done;
    logic [CNT_W-1:0]      spike_count;

    modport master (
        output in_valid, in_data,
        input  in_ready, spike_out, window_active, window_done, spike_count
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, spike_out, window_active, window_done, spike_count
    );
endinterface

// File: rtl/spike_rate_encoder_lfsr.sv
// Free-running 16-bit Galois LFSR that advances only while enabled.
// A zero seed is replaced by 1 so the register can never lock up at zero.
module spike_lfsr
    import spike_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // LFSR state: reloads the seed on reset, steps when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= (seed == 16'h0000) ? 16'h0001 : seed;
        end else if (en) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: accepts one intensity sample per window and emits
// a Bernoulli spike train of WINDOW steps, driven by an internal LFSR.
// Optional feature macro: SPIKE_ENC_REFRACTORY_EN (a spike forces the next
// step to zero while the LFSR keeps stepping).
module spike_rate_encoder
    import spike_enc_pkg::*;
#(
    parameter int          DATA_WIDTH = 8,
    parameter int          WINDOW     = 16,
    parameter logic [15:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_rate_encoder_if.slave   bus
);

    localparam int CNT_W  = $clog2(WINDOW + 1);
    localparam int STEP_W = $clog2(WINDOW);

    enc_state_t                state;
    enc_state_t                state_nxt;
    logic                      accept;
    logic                      ready;
    logic                      last_step;
    logic                      spike_nxt;
    logic [DATA_WIDTH-1:0]     intensity;
    logic [STEP_W-1:0]         step;
    logic [CNT_W-1:0]          count_q;
    logic                      spike_q;
    logic                      active_q;
    logic                      done_q;
    logic [15:0]               lfsr_q;
    logic [DATA_WIDTH-1:0]     lfsr_lo;
    logic [15-DATA_WIDTH:0]    lfsr_unused;
`ifdef SPIKE_ENC_REFRACTORY_EN
    logic                      refr_q;
`endif

    spike_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ENCODE),
        .seed (LFSR_SEED),
        .q    (lfsr_q)
    );

    // Only the low DATA_WIDTH bits of the LFSR take part in the comparison.
    assign {lfsr_unused, lfsr_lo} = lfsr_q;
    assign last_step = (step == STEP_W'(WINDOW - 1));

`ifdef SPIKE_ENC_REFRACTORY_EN
    assign spike_nxt = (lfsr_lo < intensity) && !refr_q;
`else
    assign spike_nxt = (lfsr_lo < intensity);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, ready and handshake decode.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ENCODE;
                end
            end
            ENCODE: begin
                if (last_step) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Step counter, spike register, window flags and spike tally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= '0;
            count_q  <= '0;
            spike_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPIKE_ENC_REFRACTORY_EN
            refr_q   <= 1'b0;
`endif
        end else begin
            spike_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            if (accept) begin
                step    <= '0;
                count_q <= '0;
`ifdef SPIKE_ENC_REFRACTORY_EN
                refr_q  <= 1'b0;
`endif
            end else if (state == ENCODE) begin
                spike_q  <= spike_nxt;
                active_q <= 1'b1;
                done_q   <= last_step;
                step     <= step + STEP_W'(1);
                count_q  <= count_q + CNT_W'(spike_nxt);
`ifdef SPIKE_ENC_REFRACTORY_EN
                refr_q   <= spike_nxt;
`endif
            end
        end
    end

    // Sample capture; held for the whole window.
    always_ff @(posedge clk) begin
        if (accept) begin
            intensity <= bus.in_data;
        end
    end

    assign bus.in_ready      = ready;
    assign bus.spike_out     = spike_q;
    assign bus.window_active = active_q;
    assign bus.window_done   = done_q;
    assign bus.spike_count   = count_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Testbench for spike_rate_encoder: directed windows with randomized filler,
// checked step-by-step against a behavioural Bernoulli-train model.
module tb_spike_rate_encoder;
    import spike_enc_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mlfsr;
    int   c;
    int   total;

    spike_rate_encoder_if #(.DATA_WIDTH(8), .WINDOW(W)) bus ();

    spike_rate_encoder #(
        .DATA_WIDTH (8),
        .WINDOW     (W),
        .LFSR_SEED  (DEFAULT_SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_spike"},  bus.spike_out, 0);
        chk({tag, "_active"}, bus.window_active, 0);
        chk({tag, "_done"},   bus.window_done, 0);
        chk({tag, "_count"},  bus.spike_count, 0);
        chk({tag, "_ready"},  bus.in_ready, 1);
    endtask

    // Runs one window of intensity d from a cycle in which in_ready is high.
    // hold keeps in_valid high throughout, inject pulses in_valid/in_data=50 at
    // that step, abort asserts rst just before that step's output appears.
    task automatic run_window(input logic [7:0] d, input bit hold, input int inject,
                              input int abort, output int cnt);
        int   sum  = 0;
        bit   refr = 1'b0;
        bit   prev = 1'b0;
        logic e;
        chk("ready_before", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        if (!hold) bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        chk("gap_active", bus.window_active, 0);
        chk("gap_ready",  bus.in_ready, 0);
        chk("gap_count",  bus.spike_count, 0);
        for (int s = 0; s < W; s++) begin
            if (s == abort) begin
                #2 rst = 1'b1;
                #1;
                chk_reset_outputs("abort");
                cnt = -1;
                return;
            end
            if (s == inject) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'd50;
            end else if (s == inject + 1 && !hold) begin
                bus.in_valid = 1'b0;
            end
            e = (mlfsr[7:0] < d);
`ifdef SPIKE_ENC_REFRACTORY_EN
            e = e & ~refr;
            refr = e;
`endif
            mlfsr = lfsr_next(mlfsr);
            tick();
            chk("spike",  bus.spike_out, e);
            chk("active", bus.window_active, 1);
            chk("done",   bus.window_done, (s == W - 1));
            chk("ready",  bus.in_ready, (s == W - 1));
`ifdef SPIKE_ENC_REFRACTORY_EN
            chk("refr_adjacent", prev & bus.spike_out, 0);
            prev = bus.spike_out;
`endif
            sum += int'(e);
        end
        chk("count", bus.spike_count, sum);
        cnt = sum;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst   = 1'b1;
        mlfsr = DEFAULT_SEED;
        repeat (2) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Zero intensity never fires; count holds after the window.
        run_window(8'd0, 1'b0, -1, -1, c);
        chk("zero_count", c, 0);
        tick();
        chk("hold_done",  bus.window_done, 0);
        chk("hold_count", bus.spike_count, 0);

        // Full-scale intensity.
        run_window(8'd255, 1'b0, -1, -1, c);
`ifdef SPIKE_ENC_REFRACTORY_EN
        chk("refr_max_count", (c <= 8), 1);
`endif
        tick();
        chk("hold_count_255", bus.spike_count, c);

        // Eight back-to-back windows at half scale with in_valid held high.
        total = 0;
        for (int i = 0; i < 8; i++) begin
            run_window(8'd128, 1'b1, -1, -1, c);
            total += c;
        end
        bus.in_valid = 1'b0;
        tick();
        chk("b2b_idle_active", bus.window_active, 0);
`ifndef SPIKE_ENC_REFRACTORY_EN
        chk("b2b_total_range", (total >= 40 && total <= 88), 1);
`endif

        // in_valid pulsed mid-window with different data is ignored.
        run_window(8'd100, 1'b0, 3, -1, c);
        tick();

        // Randomized intensities.
        for (int i = 0; i < 4; i++) begin
            run_window(8'($urandom), 1'b0, -1, -1, c);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset at step 5, then the same intensity replays the post-reset train.
        run_window(8'd200, 1'b0, -1, 5, c);
        tick();
        chk_reset_outputs("abort_hold");
        #2 rst = 1'b0;
        mlfsr = DEFAULT_SEED;
        tick();
        chk("abort_no_done", bus.window_done, 0);
        run_window(8'd200, 1'b0, -1, -1, c);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-coded spike transmitter feeding `input_spike` of the LIF neuron layer. It accepts one intensity sample per encoding window through a valid/ready handshake. It then emits a pseudo-random (Bernoulli-per-step) spike train for `WINDOW` timesteps, with firing probability proportional to the sample value. An internal LFSR drives the train, so the sequence is fully deterministic from reset and the bench can replay it exactly.

## Interface
- `DATA_WIDTH`, 8: intensity sample width.
- `WINDOW`, 16: timesteps per encoding window, ≥ 2.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: sample present.
- `in_data` in DATA_WIDTH: intensity; 0 never fires, 2^DATA_WIDTH−1 fires almost every step.
- `in_ready` out 1: encoder idle, sample may be accepted.
- `spike_out` out 1: registered spike, one per timestep; connects to neuron `input_spike`.
- `window_active` out 1: high while `spike_out` carries window steps.
- `window_done` out 1: one-cycle pulse coincident with the last step of a window.
- `spike_count` out $clog2(WINDOW+1): spikes emitted in the current or last window.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. The handshake (`in_valid & in_ready`) latches `in_data` into `intensity`, clears `step` and `spike_count`, and moves to ENCODE.
  - ENCODE: `in_ready`=0. Per edge:
    - `spike_out <= (lfsr[DATA_WIDTH-1:0] < intensity)`.
    - LFSR advances.
    - `step++`.
    - `spike_count += spike`.
  - On the edge where `step==WINDOW-1`, the FSM returns to IDLE.
- LFSR: 16-bit Galois, right shift, tap mask 16'hB400. It advances only in ENCODE, is not re-seeded between windows, and can never reach zero.
- Comparison is unsigned. `spike_count` saturates naturally because the maximum count is WINDOW.
- `in_valid` in ENCODE is ignored and `in_data` is not sampled.
- After a window, `spike_count` holds its value until the next handshake.
- Back-to-back windows are allowed: a handshake in the `window_done` cycle is accepted, so at most one idle cycle separates windows.
- Reset values:
  - `spike_out`, `window_active`, `window_done`, `spike_count`, `step` = 0.
  - `in_ready` = 1; state = IDLE.
  - `lfsr` = seed.

## Timing
- Handshake at edge k. Steps 0..WINDOW-1 appear on `spike_out` in the cycles after edges k+1..k+WINDOW.
- `window_active`=1 over those same WINDOW cycles.
- `window_done`=1 and `in_ready`=1 in the cycle after edge k+WINDOW, which is the last step cycle.
- Latency from acceptance to first spike decision: 1 cycle.
- `rst` mid-window: all outputs go to reset values immediately (asynchronous). The window is abandoned and no `window_done` is produced.

## Configuration
- `SPIKE_ENC_REFRACTORY_EN` defined: a spike in step n forces step n+1 to 0. The LFSR still advances on the suppressed step, so the random sequence is unchanged. The refractory flag clears on handshake. Maximum count is ceil(WINDOW/2).
- Macro undefined: no suppression, and consecutive spikes are allowed.

## Structure
- Package `spike_enc_pkg` holds:
  - FSM state enum {IDLE, ENCODE}.
  - `LFSR_TAPS` = 16'hB400.
  - `DEFAULT_SEED` = 16'hACE1.
  - The LFSR next-state function used by both RTL and bench model.
- Sub-module `spike_lfsr` (ports: `clk`, `rst`, `en`, `seed`, `q`). The top instantiates it with `en` = ENCODE.

## Test plan
- Reset, then `in_data`=0 → 16 cycles of `spike_out`=0, `window_done` pulse on the 16th active cycle, `spike_count`=0.
- `in_data`=255, macro off → `spike_out` matches the bench LFSR model step-for-step. `spike_count` = 16 minus the number of steps whose LFSR low byte = 0xFF.
- `in_data`=128 for 8 consecutive windows with `in_valid` held high → windows separated by exactly one cycle. The total spike count matches the model and falls in the range 64±24.
- `in_data`=255 with `SPIKE_ENC_REFRACTORY_EN` defined → no two adjacent `spike_out` highs and `spike_count` ≤ 8. The LFSR state at window end is identical to the macro-off run.
- Assert `rst` at step 5 of a window with `in_data`=200 → outputs immediately return to reset values with no `window_done`. A re-sent `in_data`=200 reproduces the first-after-reset spike train bit-for-bit.
- `in_valid` pulsed with `in_data`=50 during ENCODE → ignored, `in_ready` stays 0, and the current window's `intensity` is unchanged.
